// File: rtl/playlist_ctrl.sv
// -----------------------------------------------------------------------------
// playlist_ctrl
//   Song-level sequencer for the music box. Owns song selection, play/pause
//   state and the silent gap between songs. It drives the note reader with a
//   one-cycle load pulse carrying the song's start address, and it gates the
//   reader with play_en.
//
// Parameters
//   SONGS       number of songs in the start-address table (2..16)
//   SEL_W       width of the song index (>= clog2(SONGS))
//   ADDR_W      note-ROM address width
//   GAP_CYCLES  silent cycles between songs (>= 1)
//
// Ports
//   clk, rst_n   clock; asynchronous active-low reset
//   btn_play     pulse: toggle play/pause
//   btn_next     pulse: next song
//   btn_prev     pulse: previous song
//   rep_one      level: repeat the current song after the gap
//   song_end     pulse from the reader: terminator word reached
//   tbl_addr     start-address table index (always equals sel)
//   tbl_data     start address for tbl_addr (combinational, same cycle)
//   sel          current song index
//   start_addr   registered start address of the current song
//   load         one-cycle pulse: reader copies start_addr
//   play_en      reader enable
//   state_o      encoded state for debug LEDs
//
// Optional build macro
//   PLAYLIST_SHUFFLE_EN  picks the next song at gap end pseudo-randomly
//                        (8-bit LFSR); buttons stay sequential.
// -----------------------------------------------------------------------------
module playlist_ctrl #(
  parameter int SONGS      = 8,
  parameter int SEL_W      = 3,
  parameter int ADDR_W     = 16,
  parameter int GAP_CYCLES = 25000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_play,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              rep_one,
  input  logic              song_end,
  output logic [SEL_W-1:0]  tbl_addr,
  input  logic [ADDR_W-1:0] tbl_data,
  output logic [SEL_W-1:0]  sel,
  output logic [ADDR_W-1:0] start_addr,
  output logic              load,
  output logic              play_en,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  // The counter starts at GAP_CYCLES-1 and runs down to 0, so it needs
  // clog2(GAP_CYCLES) bits (at least one).
  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(SONGS - 1);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
  logic                load_q, load_d;
  logic                play_en_q, play_en_d;
  logic                resume_q, resume_d;
  logic [CNT_W-1:0]    gap_q, gap_d;

  logic [SEL_W-1:0]    inc_sel, dec_sel, gap_adv_sel, gap_sel;

  // Index arithmetic wraps modulo SONGS, not modulo 2**SEL_W.
  assign inc_sel = (sel_q == LAST_SEL) ? '0 : sel_q + SEL_W'(1);
  assign dec_sel = (sel_q == '0) ? LAST_SEL : sel_q - SEL_W'(1);

`ifdef PLAYLIST_SHUFFLE_EN
  logic [7:0]       lfsr_q;
  logic [SEL_W-1:0] cand;

  // Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1; free-running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 8'hA5;
    else        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign cand = lfsr_q[SEL_W-1:0];
  // An out-of-range or same-song candidate falls back to plain "next".
  assign gap_adv_sel = ((32'(cand) < 32'(SONGS)) && (cand != sel_q)) ? cand : inc_sel;
`else
  assign gap_adv_sel = inc_sel;
`endif

  // Song chosen when a gap finishes (or is cancelled with btn_play).
  assign gap_sel = rep_one ? sel_q : gap_adv_sel;

  // NOTE: every next-state value gets a default before the case statement, so
  // no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    start_addr_d = start_addr_q;
    load_d       = 1'b0;
    play_en_d    = play_en_q;
    resume_d     = resume_q;
    gap_d        = gap_q;

    case (state_q)
      S_IDLE: begin
        if (btn_play) begin
          resume_d = 1'b1;
          state_d  = S_LOAD;
        end else if (btn_next) begin
          sel_d = inc_sel;
        end else if (btn_prev) begin
          sel_d = dec_sel;
        end
      end

      S_LOAD: begin
        // tbl_addr already shows the new sel, so tbl_data is valid here.
        start_addr_d = tbl_data;
        load_d       = 1'b1;
        play_en_d    = resume_q;
        state_d      = resume_q ? S_PLAY : S_PAUSE;
      end

      S_PLAY: begin
        if (btn_play) begin
          play_en_d = 1'b0;
          state_d   = S_PAUSE;
        end else if (btn_next || btn_prev) begin
          sel_d     = btn_next ? inc_sel : dec_sel;
          resume_d  = 1'b1;
          play_en_d = 1'b0;
          state_d   = S_LOAD;
        end else if (song_end) begin
          play_en_d = 1'b0;
          gap_d     = GAP_LAST;
          state_d   = S_GAP;
        end
      end

      S_PAUSE: begin
        if (btn_play) begin
          play_en_d = 1'b1;
          state_d   = S_PLAY;
        end else if (btn_next || btn_prev) begin
          sel_d    = btn_next ? inc_sel : dec_sel;
          resume_d = 1'b0;
          state_d  = S_LOAD;
        end
      end

      S_GAP: begin
        if (btn_play) begin
          sel_d   = gap_sel;
          state_d = S_IDLE;
        end else if (btn_next || btn_prev) begin
          sel_d    = btn_next ? inc_sel : dec_sel;
          resume_d = 1'b1;
          state_d  = S_LOAD;
        end else if (gap_q == '0) begin
          sel_d    = gap_sel;
          resume_d = 1'b1;
          state_d  = S_LOAD;
        end else begin
          gap_d = gap_q - CNT_W'(1);
        end
      end

      default: begin
        play_en_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      start_addr_q <= '0;
      load_q       <= 1'b0;
      play_en_q    <= 1'b0;
      resume_q     <= 1'b0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      start_addr_q <= start_addr_d;
      load_q       <= load_d;
      play_en_q    <= play_en_d;
      resume_q     <= resume_d;
      gap_q        <= gap_d;
    end
  end

  assign tbl_addr   = sel_q;
  assign sel        = sel_q;
  assign start_addr = start_addr_q;
  assign load       = load_q;
  assign play_en    = play_en_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_playlist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_playlist_ctrl
//   Directed bench for playlist_ctrl with GAP_CYCLES=4 and a start-address
//   table of tbl[i] = 16'h0100*i. A table of per-cycle vectors drives the main
//   behaviour; a hand-written sequence covers asynchronous reset mid-gap.
// -----------------------------------------------------------------------------
module tb_playlist_ctrl;

  localparam int SONGS      = 8;
  localparam int SEL_W      = 3;
  localparam int ADDR_W     = 16;
  localparam int GAP_CYCLES = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              btn_play, btn_next, btn_prev, rep_one, song_end;
  logic [SEL_W-1:0]  tbl_addr, sel;
  logic [ADDR_W-1:0] tbl_data, start_addr;
  logic              load, play_en;
  logic [2:0]        state_o;

  int n_cmp  = 0;
  int n_fail = 0;

  playlist_ctrl #(
    .SONGS(SONGS), .SEL_W(SEL_W), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_play(btn_play), .btn_next(btn_next), .btn_prev(btn_prev),
    .rep_one(rep_one), .song_end(song_end),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .sel(sel), .start_addr(start_addr), .load(load),
    .play_en(play_en), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Start-address table: song i starts at 0x0100 * i.
  assign tbl_data = {5'b0, tbl_addr, 8'h00};

  typedef struct {
    logic        play, nxt, prv, rep, send;
    logic [2:0]  st;
    logic [2:0]  sel;
    logic        ld, pe;
    logic [15:0] sa;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic p, n, v, r, e,
                     input logic [2:0] st, input logic [2:0] s,
                     input logic ld, pe, input logic [15:0] sa);
    vec_t x;
    x.play = p; x.nxt = n; x.prv = v; x.rep = r; x.send = e;
    x.st = st; x.sel = s; x.ld = ld; x.pe = pe; x.sa = sa;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic [2:0] s,
                           input logic ld, pe, input logic [15:0] sa);
    check({tag, " state"},      32'(state_o),    32'(st));
    check({tag, " sel"},        32'(sel),        32'(s));
    check({tag, " tbl_addr"},   32'(tbl_addr),   32'(s));
    check({tag, " load"},       32'(load),       32'(ld));
    check({tag, " play_en"},    32'(play_en),    32'(pe));
    check({tag, " start_addr"}, 32'(start_addr), 32'(sa));
  endtask

  task automatic drive(input logic p, n, v, r, e);
    btn_play = p; btn_next = n; btn_prev = v; rep_one = r; song_end = e;
  endtask

  localparam logic [2:0] I = 3'd0, L = 3'd1, P = 3'd2, Z = 3'd3, G = 3'd4;

  initial begin
    // Expected values are the register contents just after the clock edge
    // that samples the row's inputs.
    //   play nxt prv rep end | state sel ld pe start_addr
    add(1,0,0,0,0, L, 0, 0,0, 16'h0000); // 1  play from IDLE
    add(0,0,0,0,0, P, 0, 1,1, 16'h0000); // 2  load + play_en together
    add(0,0,0,0,0, P, 0, 0,1, 16'h0000); // 3  load is one cycle
    add(0,0,1,0,0, L, 7, 0,0, 16'h0000); // 4  prev wraps 0 -> 7
    add(0,0,0,0,0, P, 7, 1,1, 16'h0700); // 5
    add(0,1,0,0,0, L, 0, 0,0, 16'h0700); // 6  next wraps 7 -> 0
    add(0,0,0,0,0, P, 0, 1,1, 16'h0000); // 7
    add(0,0,0,0,1, G, 0, 0,0, 16'h0000); // 8  song_end -> GAP
    add(0,0,0,0,0, G, 0, 0,0, 16'h0000); // 9
    add(0,0,0,0,0, G, 0, 0,0, 16'h0000); // 10
    add(0,0,0,0,0, G, 0, 0,0, 16'h0000); // 11
    add(0,0,0,0,0, L, 1, 0,0, 16'h0000); // 12 gap end advances
    add(0,0,0,0,0, P, 1, 1,1, 16'h0100); // 13 load GAP_CYCLES+1 after song_end
    add(0,0,0,1,1, G, 1, 0,0, 16'h0100); // 14 repeat-one
    add(0,0,0,1,0, G, 1, 0,0, 16'h0100); // 15
    add(0,0,0,1,0, G, 1, 0,0, 16'h0100); // 16
    add(0,0,0,1,0, G, 1, 0,0, 16'h0100); // 17
    add(0,0,0,1,0, L, 1, 0,0, 16'h0100); // 18 sel unchanged
    add(0,0,0,1,0, P, 1, 1,1, 16'h0100); // 19
    add(1,0,0,0,0, Z, 1, 0,0, 16'h0100); // 20 pause, no reload
    add(0,1,0,0,0, L, 2, 0,0, 16'h0100); // 21 next while paused
    add(0,0,0,0,0, Z, 2, 1,0, 16'h0200); // 22 loaded but stays paused
    add(1,0,0,0,0, P, 2, 0,1, 16'h0200); // 23 resume, no load
    add(0,0,0,0,0, P, 2, 0,1, 16'h0200); // 24
    add(0,1,0,0,1, L, 3, 0,0, 16'h0200); // 25 next beats song_end
    add(0,0,0,0,0, P, 3, 1,1, 16'h0300); // 26
    add(0,1,1,0,0, L, 4, 0,0, 16'h0300); // 27 next beats prev
    add(0,0,0,0,0, P, 4, 1,1, 16'h0400); // 28
    add(0,0,0,0,1, G, 4, 0,0, 16'h0400); // 29
    add(1,0,0,0,0, I, 5, 0,0, 16'h0400); // 30 play cancels gap, sel advances
    add(0,0,0,0,1, I, 5, 0,0, 16'h0400); // 31 song_end ignored in IDLE
    add(0,0,1,0,0, I, 4, 0,0, 16'h0400); // 32 prev in IDLE
    add(1,1,0,0,0, L, 4, 0,0, 16'h0400); // 33 play beats next
    add(0,0,0,0,0, P, 4, 1,1, 16'h0400); // 34
    add(0,0,0,0,1, G, 4, 0,0, 16'h0400); // 35
    add(0,0,1,0,0, L, 3, 0,0, 16'h0400); // 36 prev abandons gap
    add(0,0,0,0,0, P, 3, 1,1, 16'h0300); // 37

    drive(0,0,0,0,0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", I, 0, 0, 0, 16'h0000);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].play, vecs[i].nxt, vecs[i].prv, vecs[i].rep, vecs[i].send);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i + 1), vecs[i].st, vecs[i].sel,
                vecs[i].ld, vecs[i].pe, vecs[i].sa);
    end

    // Asynchronous reset in the middle of a gap.
    drive(0,0,0,0,1);
    @(posedge clk);
    #1;
    check("midgap enter state", 32'(state_o), 32'(G));
    drive(0,0,0,0,0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", I, 0, 0, 0, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("after_rst", I, 0, 0, 0, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
